// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and constants for the GCD scheduler slice
package gcd_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} sched_state_t;
    localparam int W = 8;
    localparam int MAX_N = 8;
endpackage

// File: rtl/nwd.sv
// nwd: iterative subtract/swap GCD core with start/ready handshake; never finishes on a zero operand
module nwd
    import gcd_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic [W-1:0] out
);
    logic [W-1:0] x, y;
    assign out = x;
    // one step per cycle: subtract the smaller, swap when out of order, finish when equal
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            x <= '0;
            y <= '0;
            ready <= 1'b0;
        end else if (start) begin
            x <= a;
            y <= b;
            ready <= 1'b0;
        end else if (!ready) begin
            if (x == y) ready <= 1'b1;
            else if (x < y) begin
                x <= y;
                y <= x;
            end else x <= x - y;
        end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or after ptr, wrapping around
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] j;
    assign any = |req;
    // scan from the farthest slot back to ptr so the nearest asserted one wins
    always_comb begin
        idx = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            idx = req[j] ? j : idx;
        end
    end
endmodule

// File: rtl/gcd_sched.sv
// gcd_sched: round-robin sharing of one nwd core among N requesters, with zero-operand bypass
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0][W-1:0] op_a,
    input  logic [N-1:0][W-1:0] op_b,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        done,
    output logic [W-1:0]        result,
    output logic                busy
);
    localparam int IW = $clog2(N);
    sched_state_t state;
    logic [IW-1:0] ptr, idx_q, arb_idx;
    logic [W-1:0] a_q, b_q, core_out;
    logic arb_any, core_start, core_ready;
    assign core_start = state == START;
    assign busy = state != IDLE;
    rr_arbiter #(.N(N)) u_arb (
        .req(req),
        .ptr(ptr),
        .idx(arb_idx),
        .any(arb_any)
    );
    nwd u_core (
        .clk(clk),
        .nrst(nrst),
        .start(core_start),
        .a(a_q),
        .b(b_q),
        .ready(core_ready),
        .out(core_out)
    );
    // service sequencer: capture in IDLE, run or bypass the core, pulse done, advance ptr
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state <= IDLE;
            ptr <= '0;
            idx_q <= '0;
            a_q <= '0;
            b_q <= '0;
            gnt <= '0;
            done <= '0;
            result <= '0;
        end else begin
            gnt <= '0;
            done <= '0;
            case (state)
                IDLE:
                    if (arb_any) begin
                        idx_q <= arb_idx;
                        a_q <= op_a[arb_idx];
                        b_q <= op_b[arb_idx];
                        gnt <= N'(1) << arb_idx;
                        if (op_a[arb_idx] == '0 || op_b[arb_idx] == '0) begin
                            result <= op_a[arb_idx] | op_b[arb_idx];
                            done <= N'(1) << arb_idx;
                            state <= DONE;
                        end else state <= START;
                    end
                START: state <= WAIT;
                WAIT:
                    if (core_ready) begin
                        result <= core_out;
                        done <= N'(1) << idx_q;
                        state <= DONE;
                    end
                DONE: begin
                    ptr <= (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_gcd_sched.sv
// tb_gcd_sched: directed scoreboard bench for gcd_sched
module tb_gcd_sched;
    localparam int N = 4;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0][7:0] op_a = '0;
    logic [N-1:0][7:0] op_b = '0;
    logic [N-1:0] gnt, done;
    logic [7:0] result;
    logic busy;
    int tests = 0, fails = 0, cyc = 0, starts = 0, gnt_at = -1, done_at = -1, ndone = 0;
    int t0, s0, n0, eg, er, ev;
    int gq[$];
    int rq[$];
    int dq[$];
    logic prev_busy = 1'b0;
    logic [N-1:0] hold = '0;

    gcd_sched #(.N(N)) dut (
        .clk(clk),
        .nrst(nrst),
        .req(req),
        .op_a(op_a),
        .op_b(op_b),
        .gnt(gnt),
        .done(done),
        .result(result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] oh(int i);
        return (i < 0) ? '0 : (N'(1) << i);
    endfunction

    // scoreboard monitor: grant order, no grant during a service, done target and result
    always @(negedge clk) begin
        if (nrst) begin
            if (dut.core_start) starts++;
            if (gnt !== '0) begin
                gnt_at = cyc;
                eg = (gq.size() > 0) ? gq.pop_front() : -1;
                tests++;
                assert (gnt === oh(eg) && !prev_busy) else begin
                    fails++;
                    $error("FAIL gnt obs=%b exp=%b prev_busy=%b", gnt, oh(eg), prev_busy);
                end
            end
            if (done !== '0) begin
                done_at = cyc;
                er = (rq.size() > 0) ? rq.pop_front() : -1;
                ev = (dq.size() > 0) ? dq.pop_front() : -1;
                tests++;
                assert (done === oh(er) && int'(result) == ev) else begin
                    fails++;
                    $error("FAIL done obs=%b/%0d exp=%b/%0d", done, result, oh(er), ev);
                end
            end
        end
        prev_busy = busy;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done !== '0) ndone++;
        req = req & ~(gnt & ~hold);
    endtask

    task automatic put(input int r, input int a, input int b, input int res);
        op_a[r] = 8'(a);
        op_b[r] = 8'(b);
        req[r] = 1'b1;
        gq.push_back(r);
        rq.push_back(r);
        dq.push_back(res);
    endtask

    task automatic wait_done(input int n);
        int st;
        st = ndone;
        for (int i = 0; i < 300 && ndone - st < n; i++) tick();
        check("done_timeout", ndone - st, n);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_gnt", int'(gnt), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_busy", int'(busy), 0);
        nrst = 1'b1;
        repeat (2) tick();
        // single core request
        t0 = cyc; s0 = starts;
        put(1, 12, 8, 4);
        wait_done(1);
        tick();
        check("t1_gnt_cyc", gnt_at - t0, 1);
        check("t1_done_cyc", done_at - t0, 7);
        check("t1_result", int'(result), 4);
        check("t1_starts", starts - s0, 1);
        repeat (3) tick();
        check("t1_hold", int'(result), 4);
        // bypass x,0 then 0,0
        t0 = cyc; s0 = starts;
        put(0, 0, 9, 9);
        wait_done(1);
        tick();
        check("byp_gnt_cyc", gnt_at - t0, 1);
        check("byp_done_cyc", done_at - t0, 1);
        check("byp_result", int'(result), 9);
        t0 = cyc;
        put(0, 0, 0, 0);
        wait_done(1);
        tick();
        check("byp0_done_cyc", done_at - t0, 1);
        check("byp0_result", int'(result), 0);
        check("byp_no_start", starts - s0, 0);
        // equal operands on requester 3 (also returns ptr to 0)
        t0 = cyc;
        put(3, 200, 200, 200);
        wait_done(1);
        tick();
        check("eq_gnt_cyc", gnt_at - t0, 1);
        check("eq_done_cyc", done_at - t0, 4);
        check("eq_result", int'(result), 200);
        // all four at once
        put(0, 18, 12, 6);
        put(1, 7, 7, 7);
        put(2, 35, 14, 7);
        put(3, 9, 6, 3);
        wait_done(4);
        tick();
        // fairness: 0 and 2 hold req continuously
        hold = 4'b0101;
        put(0, 18, 12, 6);
        put(2, 9, 6, 3);
        gq.push_back(0); rq.push_back(0); dq.push_back(6);
        gq.push_back(2); rq.push_back(2); dq.push_back(3);
        wait_done(4);
        req = '0;
        hold = '0;
        repeat (4) tick();
        check("fair_sb_empty", gq.size() + rq.size(), 0);
        // reset during WAIT
        put(1, 35, 14, 7);
        repeat (3) tick();
        check("mid_busy", int'(busy), 1);
        nrst = 1'b0;
        #1;
        check("mr_gnt", int'(gnt), 0);
        check("mr_done", int'(done), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_result", int'(result), 0);
        void'(rq.pop_back());
        void'(dq.pop_back());
        repeat (2) tick();
        nrst = 1'b1;
        n0 = ndone;
        repeat (20) tick();
        check("mr_no_done", ndone - n0, 0);
        t0 = cyc;
        put(3, 21, 14, 7);
        wait_done(1);
        tick();
        check("post_rst_gnt_cyc", gnt_at - t0, 1);
        check("post_rst_result", int'(result), 7);
        check("sb_empty", gq.size() + rq.size() + dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
